// File: rtl/matmul_result_drain_if.sv
// Result-matrix handoff from the systolic array plus the requantized output stream.
// The slave modport is the drain's view; master is the upstream/downstream environment.
interface matmul_result_drain_if #(
  parameter int M         = 16,
  parameter int N         = 16,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
);
  logic                 c_valid;
  logic [IN_WIDTH-1:0]  c_in [M*N];
  logic                 c_ack;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_last_row;
  logic                 m_last;
  logic                 busy;
  logic [15:0]          sat_count;

  modport slave (
    input  c_valid, c_in, m_ready,
    output c_ack, m_valid, m_data, m_last_row, m_last, busy, sat_count
  );

  modport master (
    output c_valid, c_in, m_ready,
    input  c_ack, m_valid, m_data, m_last_row, m_last, busy, sat_count
  );
endinterface

// File: rtl/matmul_result_drain.sv
// Snapshots the M x N result matrix in one cycle and streams it row-major,
// requantizing each element with a rounding arithmetic shift and saturation.
module matmul_result_drain #(
  parameter int M         = 16,
  parameter int N         = 16,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matmul_result_drain_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for an armed c_valid to capture a matrix
  // LOAD   | snapshot held, element 0 being requantized into the output register
  // STREAM | presenting elements; advances on each m_valid && m_ready
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam int NUM  = M * N;
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int COLW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [IN_WIDTH:0] RND  = (IN_WIDTH+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
  localparam logic signed [IN_WIDTH:0] MINV = (IN_WIDTH+1)'(-(64'sd1 << (OUT_WIDTH-1)));

  logic [1:0]          state;
  logic                armed;
  logic [IDXW-1:0]     idx;
  logic [COLW-1:0]     col;
  logic                cur_sat;
  logic [IN_WIDTH-1:0] snap [NUM];

  logic                 capture;
  logic                 xfer;
  logic [IDXW-1:0]      nxt_idx;
  logic [COLW-1:0]      nxt_col;
  logic [IDXW-1:0]      sel_idx;
  logic [COLW-1:0]      sel_col;
  logic                 ld_last_row;
  logic                 ld_last;
  logic signed [IN_WIDTH:0] x_ext;
  logic signed [IN_WIDTH:0] y;
  logic [OUT_WIDTH-1:0] rq_data;
  logic                 rq_sat;

  always_comb begin
    capture = (state == S_IDLE) && bus.c_valid && armed;
    xfer    = (state == S_STREAM) && bus.m_valid && bus.m_ready;
    nxt_idx = idx + IDXW'(1);
    nxt_col = (col == COLW'(N-1)) ? '0 : col + COLW'(1);
    // LOAD and the final element both select index 0 so the read never leaves the array
    sel_idx = ((state == S_LOAD) || (idx == IDXW'(NUM-1))) ? '0 : nxt_idx;
    sel_col = (state == S_LOAD) ? '0 : nxt_col;
    ld_last_row = (sel_col == COLW'(N-1));
    ld_last     = (sel_idx == IDXW'(NUM-1));

    // One extra bit of headroom keeps the rounding add from wrapping
    x_ext = $signed({snap[sel_idx][IN_WIDTH-1], snap[sel_idx]});
    y     = (x_ext + RND) >>> SHIFT;
    if (y > MAXV) begin
      rq_data = MAXV[OUT_WIDTH-1:0];
      rq_sat  = 1'b1;
    end else if (y < MINV) begin
      rq_data = MINV[OUT_WIDTH-1:0];
      rq_sat  = 1'b1;
    end else begin
      rq_data = y[OUT_WIDTH-1:0];
      rq_sat  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) snap <= bus.c_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      armed          <= 1'b0;
      idx            <= '0;
      col            <= '0;
      cur_sat        <= 1'b0;
      bus.c_ack      <= 1'b0;
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      bus.m_last_row <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sat_count  <= '0;
    end else begin
      bus.c_ack <= 1'b0;
      if (!bus.c_valid) armed <= 1'b1;
      else if (capture) armed <= 1'b0;

      case (state)
        S_IDLE: begin
          if (capture) begin
            state         <= S_LOAD;
            bus.c_ack     <= 1'b1;
            bus.busy      <= 1'b1;
            bus.sat_count <= '0;
            idx           <= '0;
            col           <= '0;
          end
        end
        S_LOAD: begin
          bus.m_data     <= rq_data;
          cur_sat        <= rq_sat;
          bus.m_last_row <= ld_last_row;
          bus.m_last     <= ld_last;
          bus.m_valid    <= 1'b1;
          state          <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            if (cur_sat && (bus.sat_count != 16'hFFFF))
              bus.sat_count <= bus.sat_count + 16'd1;
            if (bus.m_last) begin
              bus.m_valid    <= 1'b0;
              bus.m_last     <= 1'b0;
              bus.m_last_row <= 1'b0;
              bus.busy       <= 1'b0;
              state          <= S_IDLE;
            end else begin
              idx            <= nxt_idx;
              col            <= nxt_col;
              bus.m_data     <= rq_data;
              cur_sat        <= rq_sat;
              bus.m_last_row <= ld_last_row;
              bus.m_last     <= ld_last;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Randomized bench for matmul_result_drain: expected stream computed from each
// captured matrix with plain integer arithmetic, compared on every transfer.
module tb_matmul_result_drain;
  localparam int M = 4, N = 4, IW = 32, OW = 16, SH = 8, NUM = M * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_result_drain_if #(.M(M), .N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  matmul_result_drain #(.M(M), .N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    bit          lr;
    bit          last;
    bit          sat;
  } exp_t;

  exp_t        exp_q[$];
  int          xfer_cyc[$];
  int          total = 0, bad = 0;
  int          ack_cnt = 0, xfer_cnt = 0, cyc = 0, model_sat = 0;
  int          ready_mode = 0;
  logic [31:0] mat [NUM];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int k, input logic [31:0] x);
    exp_t   e;
    longint v;
    v = longint'($signed(x));
    v = (v + (longint'(1) << (SH - 1))) >>> SH;
    e.sat = 1'b0;
    if (v > 32767) begin
      v = 32767; e.sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768; e.sat = 1'b1;
    end
    e.data = v[15:0];
    e.lr   = (k % N) == N - 1;
    e.last = (k == NUM - 1);
    return e;
  endfunction

  // m_ready driver: 0 always ready, 1 fixed 1,0,0,1,0,1 pattern, 2 random
  initial begin
    bit pat [6];
    int p = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       begin bus.m_ready = pat[p % 6]; p++; end
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every cycle outside reset
  logic [15:0] held_data;
  logic        held_lr, held_last;
  bit          stall_prev = 0;
  exp_t        mon_e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_sat  = 0;
      stall_prev = 0;
    end else begin
      if (bus.c_ack) begin
        ack_cnt++;
        model_sat = 0;
      end
      check("sat_count", bus.sat_count, model_sat);
      if (bus.m_valid) begin
        if (stall_prev) begin
          check("stall_data", bus.m_data, held_data);
          check("stall_last_row", bus.m_last_row, held_lr);
          check("stall_last", bus.m_last, held_last);
        end
        if (bus.m_ready) begin
          stall_prev = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("m_data", bus.m_data, mon_e.data);
            check("m_last_row", bus.m_last_row, mon_e.lr);
            check("m_last", bus.m_last, mon_e.last);
            if (mon_e.sat && model_sat < 65535) model_sat++;
          end
          xfer_cyc.push_back(cyc);
          xfer_cnt++;
        end else begin
          stall_prev = 1;
          held_data  = bus.m_data;
          held_lr    = bus.m_last_row;
          held_last  = bus.m_last;
        end
      end else begin
        if (stall_prev) check("valid_dropped_in_stall", 0, 1);
        stall_prev = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_matrix();
    bus.c_in = mat;
    for (int i = 0; i < NUM; i++) exp_q.push_back(model(i, mat[i]));
  endtask

  task automatic capture(input bit hold);
    int n = 0;
    bus.c_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!bus.c_ack && n < 6);
    if (!bus.c_ack) check("ack_timeout", 0, 1);
    if (!hold) bus.c_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || bus.busy) check("drain_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_c_ack"}, bus.c_ack, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"}, bus.m_data, 0);
    check({tag, "_m_last_row"}, bus.m_last_row, 0);
    check({tag, "_m_last"}, bus.m_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_sat_count"}, bus.sat_count, 0);
  endtask

  task automatic random_matrix();
    for (int i = 0; i < NUM; i++)
      if ($urandom_range(0, 3) == 0) mat[i] = $urandom;
      else mat[i] = 32'($signed($urandom_range(0, 20000000)) - 10000000);
  endtask

  int base_x, base_a, nsat;

  initial begin
    bus.c_valid = 1'b0;
    for (int i = 0; i < NUM; i++) mat[i] = '0;
    bus.c_in = mat;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Ramp, full throughput, explicit latency
    for (int i = 0; i < NUM; i++) mat[i] = 32'(i * 256);
    base_x = xfer_cnt; base_a = ack_cnt;
    push_matrix();
    bus.c_valid = 1'b1;
    tick();
    check("ack_at_T1", bus.c_ack, 1);
    check("valid_at_T1", bus.m_valid, 0);
    check("busy_at_T1", bus.busy, 1);
    bus.c_valid = 1'b0;
    tick();
    check("ack_at_T2", bus.c_ack, 0);
    check("valid_at_T2", bus.m_valid, 1);
    check("data_at_T2", bus.m_data, 16'h0000);
    wait_done(100);
    check("ramp_xfers", xfer_cnt - base_x, 16);
    check("ramp_back_to_back", xfer_cyc[base_x + 15] - xfer_cyc[base_x], 15);
    check("ramp_acks", ack_cnt - base_a, 1);
    check("ramp_sat", bus.sat_count, 0);
    check("ramp_busy_low", bus.busy, 0);

    // Rounding
    for (int i = 0; i < NUM; i++) mat[i] = '0;
    mat[0] = 32'h0000_0180; mat[1] = 32'hFFFF_FE80; mat[2] = 32'h0000_007F; mat[3] = 32'h0000_0080;
    push_matrix();
    check("pin_round0", exp_q[0].data, 16'h0002);
    check("pin_round1", exp_q[1].data, 16'hFFFF);
    check("pin_round2", exp_q[2].data, 16'h0000);
    check("pin_round3", exp_q[3].data, 16'h0001);
    capture(0);
    wait_done(100);
    check("round_sat", bus.sat_count, 0);

    // Saturation
    for (int i = 0; i < NUM; i++) mat[i] = '0;
    mat[0] = 32'h7FFF_FFFF; mat[1] = 32'h8000_0000;
    push_matrix();
    check("pin_sat_hi", exp_q[0].data, 16'h7FFF);
    check("pin_sat_lo", exp_q[1].data, 16'h8000);
    capture(0);
    wait_done(100);
    check("sat_count_end", bus.sat_count, 2);

    // Backpressure with snapshot isolation
    ready_mode = 1;
    for (int i = 0; i < NUM; i++) mat[i] = 32'(i * 256);
    base_x = xfer_cnt;
    push_matrix();
    capture(0);
    for (int i = 0; i < NUM; i++) mat[i] = 32'hDEAD_0000;
    bus.c_in = mat;
    wait_done(200);
    check("bp_xfers", xfer_cnt - base_x, 16);

    // c_valid held across the stream and beyond, then re-armed
    ready_mode = 2;
    random_matrix();
    base_x = xfer_cnt; base_a = ack_cnt;
    push_matrix();
    capture(1);
    wait_done(300);
    repeat (10) tick();
    check("hold_acks", ack_cnt - base_a, 1);
    check("hold_xfers", xfer_cnt - base_x, 16);
    check("hold_no_restream", bus.m_valid, 0);
    bus.c_valid = 1'b0;
    tick();
    random_matrix();
    push_matrix();
    capture(0);
    wait_done(300);
    check("rearm_acks", ack_cnt - base_a, 2);
    check("rearm_xfers", xfer_cnt - base_x, 32);

    // Reset after five transfers
    ready_mode = 0;
    random_matrix();
    base_x = xfer_cnt; base_a = ack_cnt;
    push_matrix();
    capture(0);
    for (int n = 0; n < 50 && xfer_cnt < base_x + 5; n++) tick();
    check("pre_reset_xfers", xfer_cnt - base_x, 5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("midreset");
    bus.c_valid = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("no_capture_unarmed", ack_cnt - base_a, 1);
    check("idle_after_reset", bus.busy, 0);
    bus.c_valid = 1'b0;
    tick();
    base_x = xfer_cnt;
    push_matrix();
    capture(0);
    wait_done(100);
    check("restart_xfers", xfer_cnt - base_x, 16);

    // Random matrices under random backpressure
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      random_matrix();
      nsat = 0;
      for (int i = 0; i < NUM; i++) begin
        exp_t e;
        e = model(i, mat[i]);
        if (e.sat) nsat++;
      end
      push_matrix();
      capture(0);
      wait_done(300);
      check("rand_sat_total", bus.sat_count, nsat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
